sd_serializer: RTL

SD_SERIALIZER -- requirements
Module: sd_serializer

---
 rtl/sd_pkg.sv | 20 ++
 rtl/sd_bit_timer.sv | 59 +++++
 rtl/sd_serializer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/sd_pkg.sv
// ---------------------------------------------------------------------------
// sd_pkg
// Shared definitions for the serializer slice.
//   state_t        : FSM encoding (IDLE / SHIFT)
//   DEFAULT_WIDTH  : default parallel word length
//   DEFAULT_DIV_W  : default width of the bit-period divider input
//   IDLE_LEVEL     : level driven on the serial line when nothing is sent
// ---------------------------------------------------------------------------
package sd_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int   DEFAULT_WIDTH = 16;
    localparam int   DEFAULT_DIV_W = 8;
    localparam logic IDLE_LEVEL    = 1'b0;

endpackage

// File: rtl/sd_bit_timer.sv
// ---------------------------------------------------------------------------
// sd_bit_timer
// Bit-period counter. Counts 0..div_reg while run is high and wraps to 0 at
// terminal count, so each bit lasts div+1 clocks. The divider value is
// captured on start so that a word keeps its own bit period.
//   clk, rst    : clock, asynchronous active-low reset
//   clear       : synchronous clear of counter and latched divider (priority)
//   start       : begin a new word: counter to 0, capture div_in
//   run         : advance the counter (high while shifting)
//   div_in      : divider value sampled on start
//   first       : counter is at 0 (first cycle of a bit period)
//   tc          : counter equals the latched divider (last cycle of a bit)
// ---------------------------------------------------------------------------
module sd_bit_timer #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             start,
    input  logic             run,
    input  logic [DIV_W-1:0] div_in,
    output logic             first,
    output logic             tc
);

    logic [DIV_W-1:0] cnt_reg;
    logic [DIV_W-1:0] cnt_next;
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] div_next;

    assign tc    = (cnt_reg == div_reg);
    assign first = (cnt_reg == '0);

    always_comb begin
        cnt_next = cnt_reg;
        div_next = div_reg;
        if (clear) begin
            cnt_next = '0;
            div_next = '0;
        end else if (start) begin
            cnt_next = '0;
            div_next = div_in;
        end else if (run) begin
            cnt_next = tc ? '0 : cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
            div_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
            div_reg <= div_next;
        end
    end

endmodule

// File: rtl/sd_serializer.sv
// ---------------------------------------------------------------------------
// sd_serializer
// Parallel-to-serial converter with a one-word holding register in front of
// the shift register. Each bit is held for div+1 clocks; bit order and bit
// period are captured when a word moves from the holding register into the
// shift register, so changes on msb_first/div never disturb a word in flight.
// The serial outputs (x, bit_strobe, word_done) are registered one stage
// after the shift register, which gives the two-edge accept-to-first-bit
// latency and keeps word_done aligned with the last bit on x.
//   clk, rst          : clock, asynchronous active-low reset
//   din, din_valid    : word offered for transmission
//   din_ready         : holding register empty (and no flush)
//   msb_first, div    : bit order / bit period for the next loaded word
//   flush             : synchronous abort of held and in-flight data
//   x                 : registered serial output, idle level 0
//   bit_strobe        : pulse in the first cycle of each bit on x
//   busy              : FSM is in SHIFT
//   word_done         : pulse in the last cycle of a word's last bit on x
//   words_sent        : completed word count, wraps at 256
// ---------------------------------------------------------------------------
module sd_serializer
    import sd_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIV_W = DEFAULT_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             msb_first,
    input  logic [DIV_W-1:0] div,
    input  logic             flush,
    output logic             x,
    output logic             bit_strobe,
    output logic             busy,
    output logic             word_done,
    output logic [7:0]       words_sent
);

    localparam int             BCW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

    state_t           state_reg;
    state_t           state_next;

    logic [WIDTH-1:0] hold_reg;
    logic             hold_valid_reg;
    logic [WIDTH-1:0] shift_reg;
    logic             msb_reg;
    logic [BCW-1:0]   bit_cnt_reg;
    logic             x_reg;
    logic             strobe_reg;
    logic             done_reg;
    logic [7:0]       words_reg;

    logic             period_first;
    logic             period_tc;
    logic             last_bit;
    logic             accept;
    logic             load;
    logic             advance;
    logic             finish;
    logic             cur_bit;
    logic             strobe_int;
    logic             timer_clear;

    // Accept and drain of the holding register can never coincide: accept
    // needs it empty, drain needs it full.
    assign din_ready  = !hold_valid_reg && !flush;
    assign accept     = din_valid && din_ready;
    assign last_bit   = (bit_cnt_reg == LAST_BIT);
    assign busy       = (state_reg == ST_SHIFT);
    assign x          = x_reg;
    assign bit_strobe = strobe_reg;
    assign word_done  = done_reg;
    assign words_sent = words_reg;

    // Ending a word with nothing queued returns the timer to its reset value.
    assign timer_clear = flush || (finish && !hold_valid_reg);

    sd_bit_timer #(
        .DIV_W (DIV_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .start  (load),
        .run    (busy),
        .div_in (div),
        .first  (period_first),
        .tc     (period_tc)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:  if (hold_valid_reg) state_next = ST_SHIFT;
                ST_SHIFT: if (finish && !hold_valid_reg) state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: datapath controls and the pre-register serial values
    always_comb begin
        load       = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;
        cur_bit    = IDLE_LEVEL;
        strobe_int = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                load = hold_valid_reg;
            end
            ST_SHIFT: begin
                cur_bit    = msb_reg ? shift_reg[WIDTH-1] : shift_reg[0];
                strobe_int = period_first;
                if (period_tc) begin
                    if (last_bit) begin
                        finish = 1'b1;
                        load   = hold_valid_reg;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: begin
                load = 1'b0;
            end
        endcase
    end

    // Holding register, shift register, output stage and word counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_reg       <= '0;
            hold_valid_reg <= 1'b0;
            shift_reg      <= '0;
            msb_reg        <= 1'b0;
            bit_cnt_reg    <= '0;
            x_reg          <= IDLE_LEVEL;
            strobe_reg     <= 1'b0;
            done_reg       <= 1'b0;
            words_reg      <= '0;
        end else if (flush) begin
            hold_valid_reg <= 1'b0;
            shift_reg      <= '0;
            bit_cnt_reg    <= '0;
            x_reg          <= IDLE_LEVEL;
            strobe_reg     <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            if (accept) begin
                hold_reg       <= din;
                hold_valid_reg <= 1'b1;
            end else if (load) begin
                hold_valid_reg <= 1'b0;
            end

            if (load) begin
                shift_reg   <= hold_reg;
                msb_reg     <= msb_first;
                bit_cnt_reg <= '0;
            end else if (advance) begin
                shift_reg   <= msb_reg ? (shift_reg << 1) : (shift_reg >> 1);
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end else if (finish) begin
                bit_cnt_reg <= '0;
            end

            x_reg      <= cur_bit;
            strobe_reg <= strobe_int;
            done_reg   <= finish;
            if (finish) begin
                words_reg <= words_reg + 8'd1;
            end
        end
    end

endmodule
